// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 responder, pins oversampled in the masterClk domain
// Optional macro SPI_SLAVE_OVERRUN_EN adds rxAck/overrun receive flow control.
module spi_slave #(
  parameter logic [7:0] FILL_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       masterClk,
  input  logic       rst,
  input  logic       SCK,
  input  logic       CS,
  input  logic       MOSI,
  input  logic       DC,
  output logic       MISO,
  output logic       misoEn,
  output logic [7:0] rxData,
  output logic       rxDC,
  output logic       rxValid,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txAck,
  output logic       busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic       rxAck,
  output logic       overrun
`endif
);

  // Pin vector layout: {DC, MOSI, CS, SCK}; CS resets to deasserted.
  localparam logic [3:0] PIN_RST = 4'b0010;

  logic [3:0] sync_q [SYNC_STAGES];
  logic [1:0] hist_q;
  logic       sck_s, cs_s, mosi_s, dc_s;
  logic       sck_rise, sck_fall, cs_rise, cs_fall;

  logic       active_q, active_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_dc_q, rx_dc_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_ack_q, tx_ack_d;
  logic       byte_done;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_pending_q, rx_pending_d;
  logic       overrun_q, overrun_d;
`endif

  assign sck_s    = sync_q[SYNC_STAGES-1][0];
  assign cs_s     = sync_q[SYNC_STAGES-1][1];
  assign mosi_s   = sync_q[SYNC_STAGES-1][2];
  assign dc_s     = sync_q[SYNC_STAGES-1][3];
  assign sck_rise = sck_s & ~hist_q[0];
  assign sck_fall = ~sck_s & hist_q[0];
  assign cs_rise  = cs_s & ~hist_q[1];
  assign cs_fall  = ~cs_s & hist_q[1];

  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_RST;
      hist_q     <= 2'b10;
      active_q   <= 1'b0;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 7'd0;
      tx_shift_q <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_dc_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_ack_q   <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      rx_pending_q <= 1'b0;
      overrun_q    <= 1'b0;
`endif
    end else begin
      sync_q[0] <= {DC, MOSI, CS, SCK};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q     <= {cs_s, sck_s};
      active_q   <= active_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_dc_q    <= rx_dc_d;
      rx_valid_q <= rx_valid_d;
      tx_ack_q   <= tx_ack_d;
`ifdef SPI_SLAVE_OVERRUN_EN
      rx_pending_q <= rx_pending_d;
      overrun_q    <= overrun_d;
`endif
    end
  end

  always_comb begin
    active_d   = active_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_dc_d    = rx_dc_q;
    rx_valid_d = 1'b0;
    tx_ack_d   = 1'b0;
    byte_done  = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    rx_pending_d = rx_pending_q;
    overrun_d    = overrun_q;
`endif

    // CS edges take priority so a same-cycle SCK edge is dropped.
    if (cs_rise) begin
      active_d  = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (cs_fall) begin
      active_d   = 1'b1;
      bit_cnt_d  = 3'd0;
      tx_shift_d = txValid ? txData : FILL_BYTE;
      tx_ack_d   = txValid;
    end else if (active_q) begin
      if (sck_rise) begin
        rx_shift_d = {rx_shift_q[5:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_done  = 1'b1;
          tx_shift_d = txValid ? txData : FILL_BYTE;
          tx_ack_d   = txValid;
        end
      end else if (sck_fall && bit_cnt_q != 3'd0) begin
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    if (byte_done) begin
      if (rx_pending_q) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d    = {rx_shift_q, mosi_s};
        rx_dc_d      = dc_s;
        rx_valid_d   = 1'b1;
        rx_pending_d = 1'b1;
      end
    end
    if (rxAck) begin
      rx_pending_d = 1'b0;
      overrun_d    = 1'b0;
    end
`else
    if (byte_done) begin
      rx_data_d  = {rx_shift_q, mosi_s};
      rx_dc_d    = dc_s;
      rx_valid_d = 1'b1;
    end
`endif
  end

  assign MISO    = active_q & tx_shift_q[7];
  assign misoEn  = active_q;
  assign busy    = active_q;
  assign rxData  = rx_data_q;
  assign rxDC    = rx_dc_q;
  assign rxValid = rx_valid_q;
  assign txAck   = tx_ack_q;
`ifdef SPI_SLAVE_OVERRUN_EN
  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench for spi_slave acting as the SPI master
module tb_spi_slave;
  localparam int HALF = 6;

  logic       masterClk = 1'b0;
  logic       rst = 1'b1;
  logic       SCK = 1'b0, CS = 1'b1, MOSI = 1'b0, DC = 1'b0;
  logic       MISO, misoEn, rxDC, rxValid, txAck, busy;
  logic [7:0] rxData;
  logic [7:0] txData = 8'h00;
  logic       txValid = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rxAck = 1'b0;
  logic       overrun;
`endif

  int n_tests = 0, n_fail = 0;
  int rx_cnt = 0, ack_cnt = 0;
  int r0, a0;
  logic [7:0] got;

  spi_slave #(.FILL_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
    .masterClk(masterClk), .rst(rst), .SCK(SCK), .CS(CS), .MOSI(MOSI), .DC(DC),
    .MISO(MISO), .misoEn(misoEn), .rxData(rxData), .rxDC(rxDC), .rxValid(rxValid),
    .txData(txData), .txValid(txValid), .txAck(txAck), .busy(busy)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .rxAck(rxAck), .overrun(overrun)
`endif
  );

  always #5 masterClk = ~masterClk;

  always @(negedge masterClk) begin
    if (rxValid) rx_cnt++;
    if (txAck) ack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge masterClk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] b, input logic dc, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = b[7-i];
      DC   = dc;
      tick(HALF);
      rx = {rx[6:0], MISO};
      SCK = 1'b1;
      tick(HALF);
      SCK = 1'b0;
    end
    tick(HALF);
  endtask

  task automatic cs_low();
    CS = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    CS = 1'b1;
    tick(HALF);
  endtask

  task automatic ack_rx();
`ifdef SPI_SLAVE_OVERRUN_EN
    rxAck = 1'b1;
    tick(1);
    rxAck = 1'b0;
`endif
    tick(1);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_rxData", rxData, 8'h00);
    check("rst_rxValid", rxValid, 1'b0);
    check("rst_MISO", MISO, 1'b0);
    check("rst_misoEn", misoEn, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_txAck", txAck, 1'b0);

    // Fill byte out, A5 in
    r0 = rx_cnt; a0 = ack_cnt;
    cs_low();
    check("t1_busy", busy, 1'b1);
    check("t1_misoEn", misoEn, 1'b1);
    xfer(8'hA5, 1'b0, 8, got);
    check("t1_rxData", rxData, 8'hA5);
    check("t1_rxDC", rxDC, 1'b0);
    check("t1_rxcnt", rx_cnt - r0, 1);
    check("t1_miso", got, 8'hFF);
    check("t1_acks", ack_cnt - a0, 0);
    cs_high();
    check("t1_MISO_idle", MISO, 1'b0);
    check("t1_misoEn_idle", misoEn, 1'b0);
    ack_rx();

    // Loaded tx byte at CS fall
    r0 = rx_cnt; a0 = ack_cnt;
    txData = 8'h3C; txValid = 1'b1;
    cs_low();
    txValid = 1'b0;
    check("t2_ack_csfall", ack_cnt - a0, 1);
    xfer(8'h00, 1'b0, 8, got);
    check("t2_miso", got, 8'h3C);
    check("t2_rxData", rxData, 8'h00);
    check("t2_acks", ack_cnt - a0, 1);
    cs_high();
    ack_rx();

    // Back-to-back bytes in one CS window
    r0 = rx_cnt; a0 = ack_cnt;
    txData = 8'h55; txValid = 1'b1;
    cs_low();
    xfer(8'h12, 1'b0, 8, got);
    check("t3_miso0", got, 8'h55);
    check("t3_rxData0", rxData, 8'h12);
    check("t3_rxDC0", rxDC, 1'b0);
    txValid = 1'b0;
    ack_rx();
    xfer(8'h34, 1'b1, 8, got);
    check("t3_miso1", got, 8'h55);
    check("t3_rxData1", rxData, 8'h34);
    check("t3_rxDC1", rxDC, 1'b1);
    check("t3_rxcnt", rx_cnt - r0, 2);
    check("t3_acks", ack_cnt - a0, 2);
    cs_high();
    ack_rx();

    // Aborted partial byte, then full frame
    r0 = rx_cnt;
    cs_low();
    xfer(8'hF0, 1'b0, 5, got);
    cs_high();
    check("t4_misoEn_gap", misoEn, 1'b0);
    check("t4_rxcnt_partial", rx_cnt - r0, 0);
    cs_low();
    xfer(8'hC3, 1'b0, 8, got);
    cs_high();
    check("t4_rxData", rxData, 8'hC3);
    check("t4_rxcnt", rx_cnt - r0, 1);
    ack_rx();

    // Reset mid-frame
    cs_low();
    xfer(8'hAA, 1'b1, 4, got);
    rst = 1'b1;
    tick(1);
    check("t5_rxData", rxData, 8'h00);
    check("t5_rxDC", rxDC, 1'b0);
    check("t5_MISO", MISO, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_misoEn", misoEn, 1'b0);
    CS = 1'b1; SCK = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
    r0 = rx_cnt;
    cs_low();
    xfer(8'h81, 1'b0, 8, got);
    cs_high();
    check("t5_rxData_after", rxData, 8'h81);
    check("t5_rxcnt", rx_cnt - r0, 1);
    ack_rx();

`ifdef SPI_SLAVE_OVERRUN_EN
    r0 = rx_cnt;
    cs_low();
    xfer(8'h11, 1'b0, 8, got);
    xfer(8'h22, 1'b0, 8, got);
    cs_high();
    check("ov_rxData", rxData, 8'h11);
    check("ov_flag", overrun, 1'b1);
    check("ov_rxcnt", rx_cnt - r0, 1);
    ack_rx();
    check("ov_cleared", overrun, 1'b0);
    r0 = rx_cnt;
    cs_low();
    xfer(8'h33, 1'b0, 8, got);
    cs_high();
    check("ov_rxData_next", rxData, 8'h33);
    check("ov_rxcnt_next", rx_cnt - r0, 1);
    ack_rx();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
